// File: rtl/br_retire_upd.sv
// br_retire_upd: retires branches from the branch ordering buffer, trains the predictors, requests recovery on a mispredict
module br_retire_upd #(
    parameter int CNTWIDTH = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                flush_i,
    input  logic                br_vld_rt_i,
    input  logic                br_taken_rt_i,
    input  logic [63:0]         br_tgt_rt_i,
    output logic                br_rdy_o,
    input  logic                bob_valid_i,
    input  logic [63:0]         bob_brpc_i,
    input  logic                bob_brdir_i,
    input  logic                bob_ch_we_i,
    input  logic                bob_ch_dir_i,
    input  logic [9:0]          bob_bht_i,
    input  logic [11:0]         bob_bhr_i,
    input  logic [3:0]          bob_rasptr_i,
    output logic                bob_re_o,
    output logic                lht_we_o,
    output logic [9:0]          lht_idx_o,
    output logic [9:0]          lht_data_o,
    output logic                lpht_we_o,
    output logic [9:0]          lpht_idx_o,
    output logic                gpht_we_o,
    output logic [11:0]         gpht_idx_o,
    output logic                pht_taken_o,
    output logic                ch_we_o,
    output logic [11:0]         ch_idx_o,
    output logic                ch_dir_o,
    output logic                recov_o,
    output logic [63:0]         recov_pc_o,
    output logic [11:0]         recov_bhr_o,
    output logic [3:0]          recov_rasptr_o,
    output logic [CNTWIDTH-1:0] br_cnt_o,
    output logic [CNTWIDTH-1:0] mispred_cnt_o,
    output logic                bob_underrun_o
);
    typedef enum logic [1:0] {IDLE, UPD, RECOV} state_t;

    state_t      state, state_nxt;
    logic [63:0] c_brpc, c_tgt;
    logic        c_brdir, c_ch_we, c_ch_dir, c_taken;
    logic [9:0]  c_bht;
    logic [11:0] c_bhr;
    logic [3:0]  c_rasptr;
    logic        accept, mispred, upd_we, underrun;

    assign accept   = br_vld_rt_i && (state == IDLE) && bob_valid_i && !flush_i;
    assign underrun = br_vld_rt_i && (state == IDLE) && !bob_valid_i && !flush_i;
    assign mispred  = c_taken != c_brdir;
    assign upd_we   = (state == UPD) && !flush_i;

    assign br_rdy_o    = state == IDLE;
    assign bob_re_o    = accept;
    assign lht_we_o    = upd_we;
    assign lpht_we_o   = upd_we;
    assign gpht_we_o   = upd_we;
    assign ch_we_o     = upd_we && c_ch_we;
    assign recov_o     = (state == RECOV) && !flush_i;
    assign lht_idx_o   = c_brpc[11:2];
    assign lht_data_o  = {c_bht[8:0], c_taken};
    assign lpht_idx_o  = c_bht;
    assign gpht_idx_o  = c_bhr;
    assign ch_idx_o    = c_bhr;
    assign pht_taken_o = c_taken;
    assign ch_dir_o    = c_ch_dir == c_taken;

    // next state: flush always returns to IDLE, UPD goes to RECOV only on a mispredict
    always_comb begin
        state_nxt = IDLE;
        state_nxt = flush_i ? IDLE : accept ? UPD : (state == UPD && mispred) ? RECOV : IDLE;
    end

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // capture the head entry on accept; latch the redirect payload when a mispredict leaves UPD
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            c_brpc         <= '0;
            c_tgt          <= '0;
            c_brdir        <= 1'b0;
            c_ch_we        <= 1'b0;
            c_ch_dir       <= 1'b0;
            c_taken        <= 1'b0;
            c_bht          <= '0;
            c_bhr          <= '0;
            c_rasptr       <= '0;
            recov_pc_o     <= '0;
            recov_bhr_o    <= '0;
            recov_rasptr_o <= '0;
        end else begin
            if (accept) begin
                c_brpc   <= bob_brpc_i;
                c_tgt    <= br_tgt_rt_i;
                c_brdir  <= bob_brdir_i;
                c_ch_we  <= bob_ch_we_i;
                c_ch_dir <= bob_ch_dir_i;
                c_taken  <= br_taken_rt_i;
                c_bht    <= bob_bht_i;
                c_bhr    <= bob_bhr_i;
                c_rasptr <= bob_rasptr_i;
            end
            if (upd_we && mispred) begin
                recov_pc_o     <= c_taken ? c_tgt : c_brpc + 64'd4;
                recov_bhr_o    <= {c_bhr[10:0], c_taken};
                recov_rasptr_o <= c_rasptr;
            end
        end
    end

    // saturating statistics and sticky underrun flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            br_cnt_o       <= '0;
            mispred_cnt_o  <= '0;
            bob_underrun_o <= 1'b0;
        end else begin
            if (accept && !(&br_cnt_o)) br_cnt_o <= br_cnt_o + CNTWIDTH'(1);
            if (upd_we && mispred && !(&mispred_cnt_o)) mispred_cnt_o <= mispred_cnt_o + CNTWIDTH'(1);
            if (underrun) bob_underrun_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_br_retire_upd.sv
// tb_br_retire_upd: directed bench for br_retire_upd, with a narrow-counter instance for saturation
module tb_br_retire_upd;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        br_vld_rt_i = 1'b0;
    logic        br_taken_rt_i = 1'b0;
    logic [63:0] br_tgt_rt_i = '0;
    logic        bob_valid_i = 1'b0;
    logic [63:0] bob_brpc_i = '0;
    logic        bob_brdir_i = 1'b0;
    logic        bob_ch_we_i = 1'b0;
    logic        bob_ch_dir_i = 1'b0;
    logic [9:0]  bob_bht_i = '0;
    logic [11:0] bob_bhr_i = '0;
    logic [3:0]  bob_rasptr_i = '0;

    logic        br_rdy_o, bob_re_o, lht_we_o, lpht_we_o, gpht_we_o, pht_taken_o;
    logic        ch_we_o, ch_dir_o, recov_o, bob_underrun_o;
    logic [9:0]  lht_idx_o, lht_data_o, lpht_idx_o;
    logic [11:0] gpht_idx_o, ch_idx_o, recov_bhr_o;
    logic [63:0] recov_pc_o;
    logic [3:0]  recov_rasptr_o;
    logic [15:0] br_cnt_o, mispred_cnt_o;

    logic        s_br_rdy, s_bob_re, s_lht_we, s_lpht_we, s_gpht_we, s_pht_taken;
    logic        s_ch_we, s_ch_dir, s_recov, s_underrun;
    logic [9:0]  s_lht_idx, s_lht_data, s_lpht_idx;
    logic [11:0] s_gpht_idx, s_ch_idx, s_recov_bhr;
    logic [63:0] s_recov_pc;
    logic [3:0]  s_recov_rasptr;
    logic [3:0]  s_br_cnt, s_mispred_cnt;

    int chk_cnt = 0;
    int pass_cnt = 0;

    always #5 clock = ~clock;

    br_retire_upd u_dut (
        .clock(clock), .reset_n(reset_n), .flush_i(flush_i),
        .br_vld_rt_i(br_vld_rt_i), .br_taken_rt_i(br_taken_rt_i), .br_tgt_rt_i(br_tgt_rt_i),
        .br_rdy_o(br_rdy_o), .bob_valid_i(bob_valid_i), .bob_brpc_i(bob_brpc_i),
        .bob_brdir_i(bob_brdir_i), .bob_ch_we_i(bob_ch_we_i), .bob_ch_dir_i(bob_ch_dir_i),
        .bob_bht_i(bob_bht_i), .bob_bhr_i(bob_bhr_i), .bob_rasptr_i(bob_rasptr_i),
        .bob_re_o(bob_re_o), .lht_we_o(lht_we_o), .lht_idx_o(lht_idx_o), .lht_data_o(lht_data_o),
        .lpht_we_o(lpht_we_o), .lpht_idx_o(lpht_idx_o), .gpht_we_o(gpht_we_o), .gpht_idx_o(gpht_idx_o),
        .pht_taken_o(pht_taken_o), .ch_we_o(ch_we_o), .ch_idx_o(ch_idx_o), .ch_dir_o(ch_dir_o),
        .recov_o(recov_o), .recov_pc_o(recov_pc_o), .recov_bhr_o(recov_bhr_o),
        .recov_rasptr_o(recov_rasptr_o), .br_cnt_o(br_cnt_o), .mispred_cnt_o(mispred_cnt_o),
        .bob_underrun_o(bob_underrun_o)
    );

    br_retire_upd #(.CNTWIDTH(4)) u_sat (
        .clock(clock), .reset_n(reset_n), .flush_i(flush_i),
        .br_vld_rt_i(br_vld_rt_i), .br_taken_rt_i(br_taken_rt_i), .br_tgt_rt_i(br_tgt_rt_i),
        .br_rdy_o(s_br_rdy), .bob_valid_i(bob_valid_i), .bob_brpc_i(bob_brpc_i),
        .bob_brdir_i(bob_brdir_i), .bob_ch_we_i(bob_ch_we_i), .bob_ch_dir_i(bob_ch_dir_i),
        .bob_bht_i(bob_bht_i), .bob_bhr_i(bob_bhr_i), .bob_rasptr_i(bob_rasptr_i),
        .bob_re_o(s_bob_re), .lht_we_o(s_lht_we), .lht_idx_o(s_lht_idx), .lht_data_o(s_lht_data),
        .lpht_we_o(s_lpht_we), .lpht_idx_o(s_lpht_idx), .gpht_we_o(s_gpht_we), .gpht_idx_o(s_gpht_idx),
        .pht_taken_o(s_pht_taken), .ch_we_o(s_ch_we), .ch_idx_o(s_ch_idx), .ch_dir_o(s_ch_dir),
        .recov_o(s_recov), .recov_pc_o(s_recov_pc), .recov_bhr_o(s_recov_bhr),
        .recov_rasptr_o(s_recov_rasptr), .br_cnt_o(s_br_cnt), .mispred_cnt_o(s_mispred_cnt),
        .bob_underrun_o(s_underrun)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [63:0] pc, input logic dir, input logic chwe, input logic chdir,
                           input logic [9:0] bht, input logic [11:0] bhr, input logic [3:0] ras,
                           input logic t, input logic [63:0] tgt);
        bob_valid_i   = 1'b1;
        bob_brpc_i    = pc;
        bob_brdir_i   = dir;
        bob_ch_we_i   = chwe;
        bob_ch_dir_i  = chdir;
        bob_bht_i     = bht;
        bob_bhr_i     = bhr;
        bob_rasptr_i  = ras;
        br_vld_rt_i   = 1'b1;
        br_taken_rt_i = t;
        br_tgt_rt_i   = tgt;
        #1;
    endtask

    initial begin
        #2;
        chk("rst_rdy", br_rdy_o, 1);
        chk("rst_re", bob_re_o, 0);
        chk("rst_lht_we", lht_we_o, 0);
        chk("rst_recov", recov_o, 0);
        chk("rst_recov_pc", recov_pc_o, 0);
        chk("rst_br_cnt", br_cnt_o, 0);
        chk("rst_mis_cnt", mispred_cnt_o, 0);
        chk("rst_underrun", bob_underrun_o, 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // correctly predicted taken branch
        present(64'h1000, 1, 0, 0, 10'h155, 12'hABC, 4'd3, 1, 64'h5000);
        chk("a_re", bob_re_o, 1);
        tick();
        br_vld_rt_i = 1'b0;
        #1;
        chk("a_rdy", br_rdy_o, 0);
        chk("a_lht_we", lht_we_o, 1);
        chk("a_lht_idx", lht_idx_o, 10'h000);
        chk("a_lht_data", lht_data_o, 10'h2AB);
        chk("a_lpht", {lpht_we_o, lpht_idx_o}, {1'b1, 10'h155});
        chk("a_gpht", {gpht_we_o, gpht_idx_o}, {1'b1, 12'hABC});
        chk("a_pht_taken", pht_taken_o, 1);
        chk("a_ch_we", ch_we_o, 0);
        chk("a_br_cnt", br_cnt_o, 1);
        tick();
        chk("a_no_recov", recov_o, 0);
        chk("a_rdy2", br_rdy_o, 1);

        // mispredict, not taken, choice update toward global
        present(64'h2000, 1, 1, 0, 10'h000, 12'h801, 4'd5, 0, 64'h7000);
        chk("b_re", bob_re_o, 1);
        tick();
        br_vld_rt_i = 1'b0;
        #1;
        chk("b_ch_we", ch_we_o, 1);
        chk("b_ch_dir", ch_dir_o, 1);
        chk("b_ch_idx", ch_idx_o, 12'h801);
        chk("b_pht_taken", pht_taken_o, 0);
        tick();
        chk("b_recov", recov_o, 1);
        chk("b_recov_pc", recov_pc_o, 64'h2004);
        chk("b_recov_bhr", recov_bhr_o, 12'h002);
        chk("b_recov_ras", recov_rasptr_o, 4'd5);
        chk("b_mis_cnt", mispred_cnt_o, 1);
        chk("b_rdy_recov", br_rdy_o, 0);
        tick();
        chk("b_recov_end", recov_o, 0);
        chk("b_recov_pc_hold", recov_pc_o, 64'h2004);
        chk("b_rdy", br_rdy_o, 1);

        // correctly predicted, no choice update
        present(64'h3008, 1, 0, 1, 10'h3FF, 12'h123, 4'd1, 1, 64'h4000);
        tick();
        br_vld_rt_i = 1'b0;
        #1;
        chk("c_ch_we", ch_we_o, 0);
        chk("c_lht_idx", lht_idx_o, 10'h002);
        chk("c_lht_data", lht_data_o, 10'h3FF);
        tick();
        chk("c_no_recov", recov_o, 0);

        // mispredict taken: redirect to target
        present(64'h4000, 0, 0, 0, 10'h000, 12'hFFF, 4'd9, 1, 64'hDEAD_BEEF_0000_0040);
        tick();
        br_vld_rt_i = 1'b0;
        tick();
        chk("d_recov", recov_o, 1);
        chk("d_recov_pc", recov_pc_o, 64'hDEAD_BEEF_0000_0040);
        chk("d_recov_bhr", recov_bhr_o, 12'hFFF);
        chk("d_recov_ras", recov_rasptr_o, 4'd9);
        tick();
        chk("d_br_cnt", br_cnt_o, 4);
        chk("d_mis_cnt", mispred_cnt_o, 2);

        // retire with empty buffer
        bob_valid_i = 1'b0;
        br_vld_rt_i = 1'b1;
        #1;
        chk("u_re", bob_re_o, 0);
        tick();
        br_vld_rt_i = 1'b0;
        #1;
        chk("u_flag", bob_underrun_o, 1);
        chk("u_rdy", br_rdy_o, 1);
        chk("u_br_cnt", br_cnt_o, 4);
        tick();
        chk("u_sticky", bob_underrun_o, 1);

        // flush during UPD of a mispredicting branch
        present(64'h5000, 1, 1, 1, 10'h0AA, 12'h055, 4'd2, 0, 64'h0);
        tick();
        br_vld_rt_i = 1'b0;
        flush_i = 1'b1;
        #1;
        chk("f_lht_we", lht_we_o, 0);
        chk("f_lpht_we", lpht_we_o, 0);
        chk("f_gpht_we", gpht_we_o, 0);
        chk("f_ch_we", ch_we_o, 0);
        tick();
        flush_i = 1'b0;
        #1;
        chk("f_rdy", br_rdy_o, 1);
        chk("f_recov", recov_o, 0);
        chk("f_mis_cnt", mispred_cnt_o, 2);
        chk("f_br_cnt", br_cnt_o, 5);

        // held request: one accept every second cycle
        present(64'h6000, 1, 0, 0, 10'h001, 12'h002, 4'd0, 1, 64'h6100);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("bb_re%0d", i), bob_re_o, (i % 2 == 0) ? 1 : 0);
            tick();
        end
        br_vld_rt_i = 1'b0;
        #1;
        chk("bb_br_cnt", br_cnt_o, 8);

        // sixteen back-to-back mispredicts saturate the narrow instance
        present(64'h7000, 1, 0, 0, 10'h000, 12'h000, 4'd4, 0, 64'h0);
        for (int k = 0; k < 16; k++) begin
            tick();
            tick();
            chk($sformatf("s_recov%0d", k), recov_o, 1);
            if (k == 15) br_vld_rt_i = 1'b0;
            tick();
        end
        chk("s_br_cnt", br_cnt_o, 24);
        chk("s_mis_cnt", mispred_cnt_o, 18);
        chk("s_sat_br", s_br_cnt, 4'hF);
        chk("s_sat_mis", s_mispred_cnt, 4'hF);
        chk("s_rdy", br_rdy_o, 1);

        // async reset in the middle of UPD
        present(64'h8000, 0, 1, 0, 10'h000, 12'h000, 4'd0, 1, 64'h0);
        tick();
        br_vld_rt_i = 1'b0;
        #1;
        chk("r_lht_we_pre", lht_we_o, 1);
        reset_n = 1'b0;
        #1;
        chk("r_lht_we", lht_we_o, 0);
        chk("r_ch_we", ch_we_o, 0);
        chk("r_rdy", br_rdy_o, 1);
        chk("r_br_cnt", br_cnt_o, 0);
        chk("r_underrun", bob_underrun_o, 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        tick();
        chk("r_no_recov", recov_o, 0);
        chk("r_recov_pc", recov_pc_o, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
